// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bundle for instr_fetch_unit: next-PC feedback, decode handshake,
// instruction-memory request/grant/response and status outputs.
// master = fetch unit, slave = surrounding next-PC logic / decode / memory.
interface instr_fetch_unit_if;
  logic [31:0] next_pc;
  logic        instr_ready;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] instr_count;
  logic        fetch_err;
  logic [1:0]  err_code;

  modport master (
    input  next_pc, instr_ready, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, pc, instr, instr_valid, instr_count,
           fetch_err, err_code
  );

  modport slave (
    output next_pc, instr_ready, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, pc, instr, instr_valid, instr_count,
           fetch_err, err_code
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: holds the architectural PC, fetches one instruction per
// retirement over a req/gnt/rvalid handshake, counts retirements and flags
// misaligned fetch targets (err_code 01).
// Optional WAIT-state timeout (err_code 10) is built when FETCH_TIMEOUT_EN
// is defined; otherwise WAIT waits indefinitely.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic        retire;
  logic        timeout_hit;

  // Parameter sanity: reset PC must be word aligned, timeout limit nonzero.
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("instr_fetch_unit: RESET_PC must be word aligned");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("instr_fetch_unit: TIMEOUT_CYCLES must be nonzero");
  end

  assign retire = (state_q == ST_VALID) && bus.instr_ready;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] tmo_q, tmo_d;

  // The edge on which the counter would reach the limit is the timeout edge;
  // a response in that same cycle takes priority in the FSM.
  assign timeout_hit = (state_q == ST_WAIT) && !bus.imem_rvalid && (tmo_q == TMO_LAST);

  // Timeout counter: cleared on WAIT entry, counts WAIT cycles without rvalid.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == ST_REQ && bus.imem_gnt) begin
      tmo_d = '0;
    end else if (state_q == ST_WAIT && !bus.imem_rvalid) begin
      tmo_d = tmo_q + 32'd1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_REQ:   if (bus.imem_gnt) state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.imem_rvalid) begin
          state_d = ST_VALID;
        end else if (timeout_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_VALID: begin
        if (retire) begin
          state_d = (bus.next_pc[1:0] == 2'b00) ? ST_REQ : ST_ERR;
        end
      end
      default:  state_d = ST_ERR;
    endcase
  end

  // Datapath next values: capture, retirement PC load/count, error latch.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    err_d   = err_q;
    code_d  = code_q;
    if (state_q == ST_WAIT && bus.imem_rvalid) begin
      instr_d = bus.imem_rdata;
    end
    if (timeout_hit) begin
      err_d  = 1'b1;
      code_d = 2'b10;
    end
    if (retire) begin
      count_d = count_q + 32'd1;
      pc_d    = bus.next_pc;
      if (bus.next_pc[1:0] != 2'b00) begin
        err_d  = 1'b1;
        code_d = 2'b01;
      end
    end
  end

  // Datapath registers; reset overrides a same-cycle retirement.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Outputs decoded from the current state and registers.
  always_comb begin
    bus.imem_req    = (state_q == ST_REQ);
    bus.instr_valid = (state_q == ST_VALID);
    bus.imem_addr   = pc_q;
    bus.pc          = pc_q;
    bus.instr       = instr_q;
    bus.instr_count = count_q;
    bus.fetch_err   = err_q;
    bus.err_code    = code_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (RESET_PC = 0x400,
// TIMEOUT_CYCLES = 8). Inputs are driven and outputs sampled 1 ns after
// each rising edge.
module tb_instr_fetch_unit;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  instr_fetch_unit_if ifc ();

  instr_fetch_unit #(
    .RESET_PC      (32'h0000_0400),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    ifc.next_pc     = '0;
    ifc.instr_ready = 1'b0;
    ifc.imem_gnt    = 1'b0;
    ifc.imem_rvalid = 1'b0;
    ifc.imem_rdata  = '0;
    tick();
    tick();

    // Reset state
    chk("rst_req",    32'(ifc.imem_req), 32'd1);
    chk("rst_valid",  32'(ifc.instr_valid), 32'd0);
    chk("rst_pc",     ifc.pc, 32'h400);
    chk("rst_instr",  ifc.instr, 32'h0);
    chk("rst_count",  ifc.instr_count, 32'd0);
    chk("rst_err",    32'(ifc.fetch_err), 32'd0);
    chk("rst_code",   32'(ifc.err_code), 32'd0);

    // First fetch: zero-wait memory, 3-cycle period
    reset = 1'b0;
    ifc.imem_gnt = 1'b1;
    chk("f1_addr", ifc.imem_addr, 32'h400);
    tick();                                   // -> WAIT
    chk("f1_wait_req", 32'(ifc.imem_req), 32'd0);
    ifc.imem_gnt    = 1'b0;
    ifc.imem_rvalid = 1'b1;
    ifc.imem_rdata  = 32'h2008_0005;
    tick();                                   // -> VALID
    ifc.imem_rvalid = 1'b0;
    ifc.imem_rdata  = 32'hFFFF_FFFF;
    chk("f1_instr", ifc.instr, 32'h2008_0005);
    chk("f1_valid", 32'(ifc.instr_valid), 32'd1);
    ifc.instr_ready = 1'b1;
    ifc.next_pc     = 32'h404;
    tick();                                   // retire -> REQ
    ifc.instr_ready = 1'b0;
    chk("f1_count", ifc.instr_count, 32'd1);
    chk("f2_addr",  ifc.imem_addr, 32'h404);
    chk("f1_valid_fall", 32'(ifc.instr_valid), 32'd0);

    // Second fetch at 0x404 -> next 0x500
    ifc.imem_gnt = 1'b1;
    tick();
    ifc.imem_gnt = 1'b0; ifc.imem_rvalid = 1'b1; ifc.imem_rdata = 32'h1111_1111;
    tick();
    ifc.imem_rvalid = 1'b0;
    chk("f2_instr", ifc.instr, 32'h1111_1111);
    ifc.instr_ready = 1'b1; ifc.next_pc = 32'h500;
    tick();
    ifc.instr_ready = 1'b0;
    chk("f3_addr", ifc.imem_addr, 32'h500);

    // Third fetch at 0x500 -> next 0x508
    ifc.imem_gnt = 1'b1;
    tick();
    ifc.imem_gnt = 1'b0; ifc.imem_rvalid = 1'b1; ifc.imem_rdata = 32'h2222_2222;
    tick();
    ifc.imem_rvalid = 1'b0;
    ifc.instr_ready = 1'b1; ifc.next_pc = 32'h508;
    tick();
    ifc.instr_ready = 1'b0;
    chk("f3_count", ifc.instr_count, 32'd3);
    chk("f3_pc",    ifc.pc, 32'h508);

    // Grant withheld 4 cycles: address and request stable; rvalid ignored in REQ
    ifc.imem_rvalid = 1'b1; ifc.imem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_addr", ifc.imem_addr, 32'h508);
      chk("stall_req",  32'(ifc.imem_req), 32'd1);
    end
    ifc.imem_rvalid = 1'b0;
    ifc.imem_gnt = 1'b1;
    tick();
    ifc.imem_gnt = 1'b0; ifc.imem_rvalid = 1'b1; ifc.imem_rdata = 32'h3333_3333;
    tick();
    ifc.imem_rvalid = 1'b0;

    // Decode holds off 5 cycles: instr stable, valid high, count unchanged
    ifc.next_pc = 32'hCCCC_0000;
    for (int i = 0; i < 5; i++) begin
      chk("hold_instr", ifc.instr, 32'h3333_3333);
      chk("hold_valid", 32'(ifc.instr_valid), 32'd1);
      chk("hold_count", ifc.instr_count, 32'd3);
      chk("hold_pc",    ifc.pc, 32'h508);
      tick();
    end

    // Misaligned target retires into ERR
    ifc.instr_ready = 1'b1; ifc.next_pc = 32'h0000_0402;
    tick();
    chk("mis_pc",    ifc.pc, 32'h402);
    chk("mis_err",   32'(ifc.fetch_err), 32'd1);
    chk("mis_code",  32'(ifc.err_code), 32'd1);
    chk("mis_count", ifc.instr_count, 32'd4);
    ifc.imem_gnt = 1'b1; ifc.imem_rvalid = 1'b1; ifc.next_pc = 32'h600;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("err_req",   32'(ifc.imem_req), 32'd0);
      chk("err_valid", 32'(ifc.instr_valid), 32'd0);
      chk("err_pc",    ifc.pc, 32'h402);
      chk("err_count", ifc.instr_count, 32'd4);
    end
    ifc.imem_gnt = 1'b0; ifc.imem_rvalid = 1'b0; ifc.instr_ready = 1'b0;

    // Reset leaves ERR
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rerr_req",  32'(ifc.imem_req), 32'd1);
    chk("rerr_err",  32'(ifc.fetch_err), 32'd0);
    chk("rerr_code", 32'(ifc.err_code), 32'd0);
    chk("rerr_pc",   ifc.pc, 32'h400);

    // Reset during WAIT; late response is dropped
    ifc.imem_gnt = 1'b1;
    tick();                                   // -> WAIT
    ifc.imem_gnt = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ifc.imem_rvalid = 1'b1; ifc.imem_rdata = 32'hDEAD_BEEF;
    tick();
    ifc.imem_rvalid = 1'b0;
    chk("rw_req",   32'(ifc.imem_req), 32'd1);
    chk("rw_addr",  ifc.imem_addr, 32'h400);
    chk("rw_valid", 32'(ifc.instr_valid), 32'd0);
    chk("rw_instr", ifc.instr, 32'h0);

    // Reset beats a same-cycle retirement
    ifc.imem_gnt = 1'b1;
    tick();
    ifc.imem_gnt = 1'b0; ifc.imem_rvalid = 1'b1; ifc.imem_rdata = 32'h4444_4444;
    tick();
    ifc.imem_rvalid = 1'b0;
    chk("rr_valid", 32'(ifc.instr_valid), 32'd1);
    reset = 1'b1; ifc.instr_ready = 1'b1; ifc.next_pc = 32'h800;
    tick();
    reset = 1'b0; ifc.instr_ready = 1'b0;
    chk("rr_count", ifc.instr_count, 32'd0);
    chk("rr_pc",    ifc.pc, 32'h400);
    chk("rr_req",   32'(ifc.imem_req), 32'd1);

`ifdef FETCH_TIMEOUT_EN
    // No response: timeout after 8 WAIT cycles
    ifc.imem_gnt = 1'b1;
    tick();                                   // -> WAIT
    ifc.imem_gnt = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("to7_err", 32'(ifc.fetch_err), 32'd0);
    chk("to7_req", 32'(ifc.imem_req), 32'd0);
    tick();
    chk("to_err",  32'(ifc.fetch_err), 32'd1);
    chk("to_code", 32'(ifc.err_code), 32'd2);
    ifc.imem_rvalid = 1'b1;
    tick();
    ifc.imem_rvalid = 1'b0;
    chk("to_stuck_valid", 32'(ifc.instr_valid), 32'd0);

    // Response on the 8th WAIT cycle: capture wins
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ifc.imem_gnt = 1'b1;
    tick();
    ifc.imem_gnt = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    ifc.imem_rvalid = 1'b1; ifc.imem_rdata = 32'h0000_55AA;
    tick();
    ifc.imem_rvalid = 1'b0;
    chk("late_instr", ifc.instr, 32'h0000_55AA);
    chk("late_valid", 32'(ifc.instr_valid), 32'd1);
    chk("late_err",   32'(ifc.fetch_err), 32'd0);
`else
    // Without the timeout option WAIT holds indefinitely
    ifc.imem_gnt = 1'b1;
    tick();
    ifc.imem_gnt = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("nto_err",   32'(ifc.fetch_err), 32'd0);
    chk("nto_req",   32'(ifc.imem_req), 32'd0);
    chk("nto_valid", 32'(ifc.instr_valid), 32'd0);
    ifc.imem_rvalid = 1'b1; ifc.imem_rdata = 32'h0000_55AA;
    tick();
    ifc.imem_rvalid = 1'b0;
    chk("nto_instr", ifc.instr, 32'h0000_55AA);
    chk("nto_vld",   32'(ifc.instr_valid), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Holds the architectural program counter and fetches one instruction per retirement from instruction memory over a request/grant/response handshake. It sits directly upstream of the next-PC logic. It drives `pc` into that logic and presents the fetched instruction to decode. On each retirement it loads the `next_pc` value that logic returns. It also counts retired instructions and detects misaligned fetch targets.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded by reset; must be word-aligned.
- `TIMEOUT_CYCLES`, default 255: WAIT-state limit; used only with `FETCH_TIMEOUT_EN`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous, active-high.
- `next_pc`  in  32  PC for the following instruction, from next-PC logic.
- `instr_ready`  in  1  decode/execute retires the presented instruction this cycle.
- `imem_gnt`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  instruction word.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; always equals `pc`.
- `pc`  out  32  PC of the instruction being fetched or presented.
- `instr`  out  32  captured instruction word.
- `instr_valid`  out  1  `instr` is valid.
- `instr_count`  out  32  retired-instruction counter.
- `fetch_err`  out  1  sticky error flag.
- `err_code`  out  2  01 = misaligned target, 10 = timeout, 00 = none.

## Operation
- FSM states: REQ, WAIT, VALID, ERR. All registers update on the rising edge of `clk`.
- Reset, applied in any state: state=REQ, `pc`=RESET_PC, `instr`=0, `instr_count`=0, `fetch_err`=0, `err_code`=00, timeout counter=0.
- Reset values of the registered outputs after that edge: `instr_valid`=0, `imem_req`=1 (the REQ state drives it).
- REQ state: `imem_req`=1 and `imem_addr`=`pc`.
  - If `imem_gnt`=1, go to WAIT.
  - Otherwise hold REQ; `imem_addr` stays stable.
  - `imem_rvalid` is ignored in REQ.
- WAIT state: `imem_req`=0.
  - If `imem_rvalid`=1, capture `imem_rdata` into `instr` and go to VALID.
- VALID state: `instr_valid`=1 and `instr` is held stable.
  - If `instr_ready`=1, the instruction retires:
    - `instr_count` increments, wrapping at 2^32-1 to 0.
    - `pc` <= `next_pc`.
  - After retirement, if `next_pc[1:0]`=00, go to REQ.
  - After retirement, if `next_pc[1:0]`≠00:
    - `pc` still loads `next_pc`.
    - `fetch_err`=1 and `err_code`=01.
    - Go to ERR.
  - If `instr_ready`=0, hold VALID.
- ERR state: `imem_req`=0 and `instr_valid`=0. Only reset exits ERR.
- `instr_ready` is ignored outside VALID.
- `imem_rvalid` is ignored outside WAIT.
- `next_pc` is sampled only at the retirement edge.
- At most one transaction is outstanding. The memory shares `reset` and drops any pending response on reset.

## Timing
- Minimum fetch-to-fetch period is 3 cycles, with zero-wait memory:
  - cycle 0: REQ with `imem_gnt`=1.
  - cycle 1: WAIT with `imem_rvalid`=1.
  - cycle 2: VALID with `instr_ready`=1.
  - cycle 3: REQ at `next_pc`.
- First request after reset: `imem_req`=1 in the first cycle after reset deasserts.
- `instr_valid` rises on the edge that captures `imem_rdata`. It falls on the retirement edge.
- `pc` changes only on a retirement edge or on reset.
- If `reset` and `instr_ready` are high in the same cycle, reset wins: no count increment and no PC load.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A counter starts at 0 on entry to WAIT and increments each WAIT cycle without `imem_rvalid`.
  - When the counter reaches `TIMEOUT_CYCLES`, the block sets `fetch_err`=1 and `err_code`=10 and goes to ERR.
  - If `imem_rvalid` arrives in the same cycle the limit is reached, the capture wins.
- `FETCH_TIMEOUT_EN` undefined: no counter is built; WAIT waits indefinitely; `err_code`=10 never occurs.

## Test plan
- Reset with `RESET_PC`=32'h0000_0400, `imem_gnt`=1, 1-cycle `imem_rvalid` returning 32'h2008_0005, `instr_ready`=1 → `imem_addr`=0x400 in cycle 0; `instr`=0x20080005 and `instr_valid`=1 in cycle 2; `instr_count`=1 after retirement.
- `next_pc`=0x404, then 0x500 on successive retirements → `imem_addr` sequence 0x400, 0x404, 0x500; `instr_count`=3.
- `imem_gnt` held low 4 cycles, then `instr_ready` held low 5 cycles → `imem_addr` stable for 4 cycles; `instr` stable and `instr_valid`=1 for 5 cycles; no count change.
- Retirement with `next_pc`=0x0000_0402 → `pc`=0x402, `fetch_err`=1, `err_code`=01, `imem_req`=0 until reset.
- `reset` asserted during WAIT, with `imem_rvalid` arriving the following cycle → that response is ignored; `imem_req`=1 at `RESET_PC`; `instr_valid`=0.
- With `FETCH_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, `imem_rvalid` never asserted → `fetch_err`=1 and `err_code`=10 after 8 WAIT cycles. Repeat with `rvalid` on cycle 8 → `instr` is captured and no error is raised.
